// File: rtl/onchip_memory_test_master.sv
// Avalon-MM test master for the single-port on-chip memory.
// Writes an incrementing pattern (seed+i) over a wrapping word range,
// reads the range back, and reports pass/fail, the number of bad words
// and the address of the first bad word.
//
// Handshake: the memory is a fixed-latency slave with no waitrequest.
// A command is issued every cycle chipselect=1 and clken=1. A read
// command's data appears on readdata exactly READ_LATENCY cycles later
// for as long as clken stays high, so clken is held through the drain.
module onchip_memory_test_master #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [ADDR_WIDTH:0]       word_count,
  input  logic [DATA_WIDTH-1:0]     seed,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [ADDR_WIDTH:0]       error_count,
  output logic [ADDR_WIDTH-1:0]     first_error_addr,
  output logic [ADDR_WIDTH-1:0]     address,
  output logic [DATA_WIDTH/8-1:0]   byteenable,
  output logic                      chipselect,
  output logic                      write,
  output logic [DATA_WIDTH-1:0]     writedata,
  output logic                      clken,
  input  logic [DATA_WIDTH-1:0]     readdata
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state;
  logic [CW-1:0]         idx;        // index of the word currently on the bus
  logic [CW-1:0]         last_idx;   // N-1 for the running test
  logic [ADDR_WIDTH-1:0] base_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic [DATA_WIDTH-1:0] pat;        // expected data for the word on the bus
  logic [1:0]            drain_cnt;

  // Expected data and address travel alongside each read until its data returns.
  logic                  pipe_vld  [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_exp  [READ_LATENCY];
  logic [ADDR_WIDTH-1:0] pipe_addr [READ_LATENCY];

  logic [CW-1:0] wc_clamped;
  logic          mismatch;
  logic [CW-1:0] err_next;

  // Clamp the requested length and evaluate the returning read word.
  always_comb begin
    wc_clamped = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
    mismatch   = pipe_vld[READ_LATENCY-1] &&
                 (readdata != pipe_exp[READ_LATENCY-1]);
    err_next   = error_count + {{ADDR_WIDTH{1'b0}}, mismatch};
  end

  // Sequencer, bus driver, compare pipeline and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      idx              <= '0;
      last_idx         <= '0;
      base_q           <= '0;
      seed_q           <= '0;
      pat              <= '0;
      drain_cnt        <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      error_count      <= '0;
      first_error_addr <= '0;
      address          <= '0;
      byteenable       <= '0;
      chipselect       <= 1'b0;
      write            <= 1'b0;
      writedata        <= '0;
      clken            <= 1'b0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_vld[k]  <= 1'b0;
        pipe_exp[k]  <= '0;
        pipe_addr[k] <= '0;
      end
    end else begin
      done <= 1'b0;

      pipe_vld[0]  <= (state == S_READ);
      pipe_exp[0]  <= pat;
      pipe_addr[0] <= address;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_vld[k]  <= pipe_vld[k-1];
        pipe_exp[k]  <= pipe_exp[k-1];
        pipe_addr[k] <= pipe_addr[k-1];
      end

      if (mismatch) begin
        error_count <= err_next;
        if (error_count == '0) begin
          first_error_addr <= pipe_addr[READ_LATENCY-1];
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            error_count      <= '0;
            first_error_addr <= '0;
            pass             <= 1'b0;
            base_q           <= base_addr;
            seed_q           <= seed;
            if (wc_clamped == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state      <= S_WRITE;
              busy       <= 1'b1;
              idx        <= '0;
              last_idx   <= wc_clamped - CW'(1);
              address    <= base_addr;
              writedata  <= seed;
              pat        <= seed;
              chipselect <= 1'b1;
              write      <= 1'b1;
              byteenable <= '1;
              clken      <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (idx == last_idx) begin
            state     <= S_READ;
            idx       <= '0;
            address   <= base_q;
            pat       <= seed_q;
            write     <= 1'b0;
            writedata <= '0;
          end else begin
            idx       <= idx + CW'(1);
            address   <= address + ADDR_WIDTH'(1);
            writedata <= writedata + DATA_WIDTH'(1);
            pat       <= pat + DATA_WIDTH'(1);
          end
        end
        S_READ: begin
          if (idx == last_idx) begin
            state      <= S_DRAIN;
            drain_cnt  <= '0;
            chipselect <= 1'b0;
            byteenable <= '0;
            address    <= '0;
          end else begin
            idx     <= idx + CW'(1);
            address <= address + ADDR_WIDTH'(1);
            pat     <= pat + DATA_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 2'(READ_LATENCY - 1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            clken <= 1'b0;
            // Includes the final word compared on this same edge.
            pass  <= (err_next == '0);
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          chipselect <= 1'b0;
          write      <= 1'b0;
          clken      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/onchip_memory_test_master.md
Name: onchip_memory_test_master

Overview:
Avalon-MM master that drives the single-port 4096x32 on-chip memory slave from the initiator side. On a start command it writes an incrementing pattern over a word range, reads the range back, compares each word against the expected value, and reports pass/fail, the error count and the first failing address. It sits beside the processor on the video system's on-chip memory port and is used for bring-up and power-on memory self-test.

Parameters:
ADDR_WIDTH, 12, word address width; memory depth is 2^ADDR_WIDTH.
DATA_WIDTH, 32, data width; byteenable width is DATA_WIDTH/8.
READ_LATENCY, 1, cycles from read address to valid readdata. Legal values: 1 or 2.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle command pulse; ignored while busy
base_addr  in  ADDR_WIDTH  first word address
word_count  in  ADDR_WIDTH+1  number of words, 0..4096
seed  in  DATA_WIDTH  pattern seed
busy  out  1  high from the accepted start until done
done  out  1  one-cycle completion pulse
pass  out  1  error_count==0 at completion; held until next start
error_count  out  ADDR_WIDTH+1  mismatching words
first_error_addr  out  ADDR_WIDTH  address of first mismatch; 0 if none
address  out  ADDR_WIDTH  to memory
byteenable  out  DATA_WIDTH/8  to memory
chipselect  out  1  to memory
write  out  1  to memory
writedata  out  DATA_WIDTH  to memory
clken  out  1  to memory
readdata  in  DATA_WIDTH  from memory

Behaviour:
- Reset values: busy=0, done=0, pass=0, error_count=0, first_error_addr=0, address=0, byteenable=0, chipselect=0, write=0, writedata=0, clken=0.
- All outputs are registered. Inputs are sampled on the clock edge where start=1 and state=IDLE.
- Word i (0..N-1) uses address (base_addr+i) mod 2^ADDR_WIDTH, so the range wraps past 4095 to 0. Expected data is (seed+i) mod 2^DATA_WIDTH.
- N = word_count. Values above 4096 are clamped to 4096.
- States:
  - IDLE: all bus outputs 0.
  - WRITE: one word per cycle; chipselect=1, write=1, byteenable=all ones, clken=1.
  - READ: one address per cycle; chipselect=1, write=0, byteenable=all ones, clken=1.
  - DRAIN: READ_LATENCY cycles; chipselect=0, clken=1.
  - DONE: one cycle; done=1, busy=0; next state IDLE.
- Transitions:
  - IDLE -> WRITE on start with N>0.
  - IDLE -> DONE on start with N=0. This gives pass=1 and error_count=0.
  - WRITE -> READ after word N-1 is issued.
  - READ -> DRAIN after address N-1 is issued.
  - DRAIN -> DONE after READ_LATENCY cycles.
- Timing: with start sampled at edge 0, word 0 is on the bus in cycle 1. Writes occupy cycles 1..N and reads occupy N+1..2N. done is high in cycle 2N+READ_LATENCY+1. busy is high in cycles 1..2N+READ_LATENCY.
- Compare: the expected data and the address for each read go through a READ_LATENCY-deep valid pipeline. readdata is compared in the cycle its valid bit emerges.
- On mismatch, error_count increments. first_error_addr is captured only on the first mismatch of a run. error_count cannot overflow, since its maximum is 4096.
- On accepted start: error_count, first_error_addr and pass are cleared.
- pass is updated in the DONE cycle.
- start during busy or DONE is ignored; no queueing.
- Reset mid-operation: the next edge returns to IDLE with reset values on all outputs. The bus deasserts immediately and no further writes occur.

Test Plan:
- base_addr=0x010, word_count=8, seed=0xA5A50000, ideal memory model -> writes 0xA5A50000..0xA5A50007 to 0x010..0x017; done in cycle 18 (READ_LATENCY=1); pass=1, error_count=0.
- Same run with the model corrupting the read of 0x013 to 0 -> error_count=1, first_error_addr=0x013, pass=0.
- base_addr=0xFFE, word_count=4, seed=0 -> addresses 0xFFE, 0xFFF, 0x000, 0x001; pass=1.
- word_count=0 -> no bus activity; done in cycle 1; pass=1.
- word_count=5000 -> 4096 writes then 4096 reads; pass=1, error_count=0.
- Reset asserted in cycle 5 of an 8-word run -> chipselect=0, write=0, busy=0 from the next cycle, no done pulse; then start with READ_LATENCY=2 completes with done in cycle 2N+3.
